// File: rtl/tdm_demux8.sv
// tdm_demux8: 8-slot TDM receiver that demultiplexes slots into a registered
// parallel frame and tracks frame alignment with a HUNT/LOCKED machine.
module tdm_demux8 #(
    parameter int W          = 1,
    parameter int MISS_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [8*W-1:0] dout,
    output logic           frame_valid,
    output logic [2:0]     slot,
    output logic           locked,
    output logic           sync_err,
    output logic [7:0]     err_count
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t                state_q, state_n;
    logic [2:0]            slot_n;
    logic [3:0]            miss_q, miss_n;
    logic [6:0][W-1:0]     sbuf_q, sbuf_n;
    logic [8*W-1:0]        dout_n;
    logic                  fv_n, se_n;
    logic [7:0]            err_n;

    assign locked = state_q == LOCKED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot        <= '0;
            miss_q      <= '0;
            sbuf_q      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_n;
            slot        <= slot_n;
            miss_q      <= miss_n;
            sbuf_q      <= sbuf_n;
            dout        <= dout_n;
            frame_valid <= fv_n;
            sync_err    <= se_n;
            err_count   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        slot_n  = slot;
        miss_n  = miss_q;
        sbuf_n  = sbuf_q;
        dout_n  = dout;
        fv_n    = 1'b0;
        se_n    = 1'b0;
        err_n   = err_count;
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    sbuf_n[0] = din;
                    slot_n    = 3'd1;
                    miss_n    = '0;
                    state_n   = LOCKED;
                end
            end else if (frame_sync && slot != 3'd0) begin
                // misplaced mark: drop the partial frame and restart at slot 0
                se_n      = 1'b1;
                err_n     = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                sbuf_n[0] = din;
                slot_n    = 3'd1;
                miss_n    = '0;
            end else if (!frame_sync && slot == 3'd0) begin
                if (miss_q + 4'd1 == 4'(MISS_LIMIT)) begin
                    state_n = HUNT;
                    slot_n  = 3'd0;
                    miss_n  = '0;
                end else begin
                    sbuf_n[0] = din;
                    slot_n    = 3'd1;
                    miss_n    = miss_q + 4'd1;
                end
            end else begin
                if (slot != 3'd7) sbuf_n[slot] = din;
                if (slot == 3'd0) miss_n = '0;
                if (slot == 3'd7) begin
                    dout_n = {din, sbuf_q};
                    fv_n   = 1'b1;
                end
                slot_n = slot + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: randomized and directed checks of tdm_demux8 against a
// slot-level behavioural model of the receiver.
module tb_tdm_demux8;
    localparam int W = 1;
    localparam int MISS_LIMIT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [7:0]   dout;
    logic         frame_valid;
    logic [2:0]   slot;
    logic         locked;
    logic         sync_err;
    logic [7:0]   err_count;

    int vectors = 0;
    int miscompares = 0;

    bit       m_locked;
    int       m_slot, m_miss, m_err;
    bit [7:0] m_buf, m_dout;
    bit       exp_fv, exp_se;

    tdm_demux8 #(.W(W), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .dout(dout), .frame_valid(frame_valid),
        .slot(slot), .locked(locked), .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = 0; m_slot = 0; m_miss = 0; m_err = 0;
        m_buf = '0; m_dout = '0; exp_fv = 0; exp_se = 0;
    endtask

    // apply one cycle of input and advance the reference model by the receiver rules
    task automatic beat(input bit v, input bit fs, input bit d);
        @(negedge clk);
        din_valid = v; frame_sync = fs; din = d;
        @(posedge clk);
        #1;
        exp_fv = 0; exp_se = 0;
        if (v) begin
            if (!m_locked) begin
                if (fs) begin m_buf[0] = d; m_slot = 1; m_miss = 0; m_locked = 1; end
            end else if (fs && m_slot != 0) begin
                exp_se = 1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                m_buf[0] = d; m_slot = 1; m_miss = 0;
            end else if (!fs && m_slot == 0) begin
                m_miss++;
                if (m_miss == MISS_LIMIT) begin m_locked = 0; m_slot = 0; m_miss = 0; end
                else begin m_buf[0] = d; m_slot = 1; end
            end else begin
                m_buf[m_slot] = d;
                if (m_slot == 0) m_miss = 0;
                if (m_slot == 7) begin m_dout = m_buf; exp_fv = 1; m_slot = 0; end
                else m_slot++;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", dout); end
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv got %b want 0", frame_valid); end
        vectors++; if (slot !== 3'd0) begin miscompares++; $display("FAIL reset_slot got %0d want 0", slot); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_se got %b want 0", sync_err); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err got %0d want 0", err_count); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        bit [7:0] p = 8'b0100_1101;
        for (int k = 0; k < 8; k++) begin
            beat(1, k == 0, p[k]);
            vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL basic_locked k=%0d got %b want 1", k, locked); end
            vectors++; if (frame_valid !== (k == 7)) begin miscompares++; $display("FAIL basic_fv k=%0d got %b want %b", k, frame_valid, k == 7); end
        end
        vectors++; if (dout !== 8'b0100_1101) begin miscompares++; $display("FAIL basic_dout got %b want 01001101", dout); end
        beat(0, 0, 0);
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_fv_drop got %b want 0", frame_valid); end
        vectors++; if (dout !== 8'b0100_1101) begin miscompares++; $display("FAIL basic_hold got %b want 01001101", dout); end
    endtask

    task automatic test_gapped();
        bit [7:0] p = 8'b0100_1101;
        int pulses = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 8; k++) begin
                beat(0, 1'($urandom), 1'($urandom));
                vectors++; if (slot !== 3'(k) || frame_valid !== 1'b0) begin miscompares++; $display("FAIL gap_idle k=%0d slot %0d fv %b want slot %0d fv 0", k, slot, frame_valid, k); end
                beat(1, k == 0, p[k]);
                pulses += int'(frame_valid);
                vectors++; if (slot !== 3'((k + 1) % 8)) begin miscompares++; $display("FAIL gap_slot k=%0d got %0d want %0d", k, slot, (k + 1) % 8); end
            end
        vectors++; if (pulses != 2) begin miscompares++; $display("FAIL gap_pulses got %0d want 2", pulses); end
        vectors++; if (dout !== 8'b0100_1101) begin miscompares++; $display("FAIL gap_dout got %b want 01001101", dout); end
    endtask

    task automatic test_misplaced();
        bit [7:0] f;
        for (int k = 0; k < 4; k++) beat(1, k == 0, 1'($urandom));
        f[0] = 1'($urandom);
        beat(1, 1, f[0]);
        vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("FAIL mis_se got %b want 1", sync_err); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL mis_err got %0d want 1", err_count); end
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL mis_fv got %b want 0", frame_valid); end
        for (int k = 1; k < 8; k++) begin
            f[k] = 1'($urandom);
            beat(1, 0, f[k]);
            vectors++; if (frame_valid !== (k == 7) || sync_err !== 1'b0) begin miscompares++; $display("FAIL mis_refill k=%0d fv %b se %b want fv %b se 0", k, frame_valid, sync_err, k == 7); end
        end
        vectors++; if (dout !== f) begin miscompares++; $display("FAIL mis_dout got %b want %b", dout, f); end
    endtask

    task automatic test_missing();
        bit [7:0] f;
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < 8; k++) begin
                f[k] = 1'($urandom);
                beat(1, 0, f[k]);
                if (n < 2 && k == 7) begin
                    vectors++; if (frame_valid !== 1'b1 || dout !== f) begin miscompares++; $display("FAIL miss_frame n=%0d fv %b dout %b want fv 1 dout %b", n, frame_valid, dout, f); end
                end
                if (n == 2) begin
                    vectors++; if (locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin miscompares++; $display("FAIL miss_unlock k=%0d locked %b fv %b se %b want 0 0 0", k, locked, frame_valid, sync_err); end
                end
            end
        for (int k = 0; k < 8; k++) begin
            f[k] = 1'($urandom);
            beat(1, k == 0, f[k]);
            vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL miss_relock k=%0d got %b want 1", k, locked); end
        end
        vectors++; if (frame_valid !== 1'b1 || dout !== f) begin miscompares++; $display("FAIL miss_relock_frame fv %b dout %b want 1 %b", frame_valid, dout, f); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit fs = (m_slot == 0 && $urandom_range(7) != 0) || $urandom_range(19) == 0;
            beat(1'($urandom_range(3) != 0), fs, 1'($urandom));
            vectors++;
            if (frame_valid !== exp_fv || sync_err !== exp_se || slot !== 3'(m_slot) || locked !== m_locked || dout !== m_dout || err_count !== 8'(m_err)) begin
                miscompares++;
                $display("FAIL rand i=%0d fv %b se %b slot %0d lk %b dout %h err %0d want %b %b %0d %b %h %0d",
                         i, frame_valid, sync_err, slot, locked, dout, err_count, exp_fv, exp_se, m_slot, m_locked, m_dout, m_err);
            end
        end
    endtask

    task automatic test_midreset();
        bit [7:0] f;
        beat(1, 1, 1);
        for (int k = 1; k < 5; k++) beat(1, 0, 1);
        @(negedge clk);
        din_valid = 1; frame_sync = 0; din = 1;
        #2 rst_n = 0;
        #1;
        vectors++;
        if (dout !== 8'h00 || frame_valid !== 1'b0 || slot !== 3'd0 || locked !== 1'b0 || sync_err !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset dout %h fv %b slot %0d lk %b se %b err %0d want all 0", dout, frame_valid, slot, locked, sync_err, err_count);
        end
        model_reset();
        din_valid = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            beat(1, 0, 1'($urandom));
            vectors++; if (frame_valid !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL midreset_hunt k=%0d fv %b lk %b want 0 0", k, frame_valid, locked); end
        end
        for (int k = 0; k < 8; k++) begin
            f[k] = 1'($urandom);
            beat(1, k == 0, f[k]);
        end
        vectors++; if (frame_valid !== 1'b1 || dout !== f) begin miscompares++; $display("FAIL midreset_relock fv %b dout %b want 1 %b", frame_valid, dout, f); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            beat(1, 1, 1'($urandom));
            vectors++; if (sync_err !== exp_se || err_count !== 8'(m_err)) begin miscompares++; $display("FAIL sat i=%0d se %b err %0d want %b %0d", i, sync_err, err_count, exp_se, m_err); end
        end
        vectors++; if (err_count !== 8'd255 || sync_err !== 1'b1) begin miscompares++; $display("FAIL sat_final err %0d se %b want 255 1", err_count, sync_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_misplaced();
        test_missing();
        test_random();
        test_midreset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receiving end of the 8:1 channel multiplexer: accepts a time-division-multiplexed stream of 8 slots per frame, with slot 0 marked by frame_sync.
- Steers each slot to its channel (1-to-8 demultiplex) and presents all 8 channels together as one registered parallel frame.
- Tracks frame alignment with a HUNT/LOCKED state machine and reports sync errors.
- Sits between the serial link and the per-channel consumers.

Parameters:
- W, 1, bits per slot (channel data width).
- MISS_LIMIT, 3, consecutive missing frame_sync marks at slot 0 before dropping lock (range 1..15).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  W  slot data
- din_valid  in  1  din/frame_sync qualify this cycle
- frame_sync  in  1  high on the beat carrying slot 0
- dout  out  8*W  frame output; channel k at dout[k*W +: W]
- frame_valid  out  1  one-cycle pulse, dout updated this cycle
- slot  out  3  slot index expected for the next valid beat
- locked  out  1  state == LOCKED
- sync_err  out  1  one-cycle pulse on misplaced frame_sync
- err_count  out  8  saturating count of sync_err events

Behaviour:
- Reset (async assert, sync-free deassert):
  - dout=0, frame_valid=0, slot=0, locked=0, sync_err=0, err_count=0.
  - Internal slot buffer=0, miss counter=0, state=HUNT.
- Cycles with din_valid=0 change nothing; frame_valid and sync_err return to 0.
- HUNT:
  - Valid beat with frame_sync=0 is discarded.
  - Valid beat with frame_sync=1: din -> buf[0], slot<=1, miss<=0, state<=LOCKED.
  - locked rises the cycle after this beat.
- LOCKED, valid beat, normal case:
  - din -> buf[slot]; slot<=slot+1 (3-bit wrap 7->0).
- Frame completion (beat at slot 7):
  - dout <= {din, buf[6..0]}, registered; frame_valid=1 the next cycle.
  - Latency: slot-7 beat edge -> dout/frame_valid visible 1 cycle later.
  - dout holds until the next completed frame.
- Misplaced sync (LOCKED, frame_sync=1 at slot!=0):
  - Partial frame discarded, no frame_valid.
  - sync_err pulses 1 cycle; err_count += 1, saturating at 255.
  - Beat treated as slot 0: buf[0]<=din, slot<=1, miss<=0.
  - State stays LOCKED.
- Missing sync (LOCKED, frame_sync=0 at slot 0):
  - Beat still captured as slot 0; miss += 1.
  - When miss reaches MISS_LIMIT: state<=HUNT, slot<=0, miss<=0, beat discarded, no sync_err.
- frame_sync=1 at slot 0: miss<=0.
- Simultaneous events:
  - Slot-7 beat carrying frame_sync=1 is a misplaced sync; the frame is not emitted.
  - err_count at 255 stays 255; sync_err still pulses.
- Reset mid-frame: partial buffer lost, no frame_valid; return to HUNT.
- buf is not cleared between frames. Every emitted frame is fully overwritten from slots 0..7 after lock or resync.

Test Plan:
- Reset, then frame_sync+din on consecutive valid beats with W=1, din pattern 1,0,1,1,0,0,1,0 (slots 0..7) -> locked=1; frame_valid pulses 1 cycle after slot 7; dout=8'b0100_1101.
- Same frames with din_valid toggling every other cycle -> identical dout; frame_valid exactly once per 8 valid beats; slot only advances on valid beats.
- Locked; frame_sync at slot 4 -> sync_err pulse; err_count=1; no frame_valid for the aborted frame; next 8 beats produce a correct frame.
- Locked; frame_sync withheld for 3 consecutive frames (MISS_LIMIT=3) -> frames 1-2 still emitted; locked=0 after the 3rd slot-0 beat; relock on the next frame_sync.
- 256 misplaced syncs -> err_count stops at 255.
- rst_n low during slot 5 -> all outputs 0 immediately (async); no frame_valid; relock required before any new frame is emitted.
